rr_mux_2x1_ctrl: RTL
====================

Name: rr_mux_2x1_ctrl

Overview:
- Two-channel round-robin arbiter and output register that generates the select for a 2:1 data mux.
- Sits directly upstream of the 2:1 mux and drives its select line.
- Merges two valid/ready source streams into one registered valid/ready output stream, tagging each word with its source.
- Throughput is one word per clock when downstream is ready.

Parameters:
- DATA_W, 8, width of each data word.
- PRIO_MODE, 0, 0 = round-robin between channels; 1 = fixed priority, channel 0 wins.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset. Asserts immediately; deasserts synchronously to clk externally.
- i0_valid  in  1  channel 0 word available.
- i0_data  in  DATA_W  channel 0 word.
- i0_ready  out  1  channel 0 word accepted this cycle.
- i1_valid  in  1  channel 1 word available.
- i1_data  in  DATA_W  channel 1 word.
- i1_ready  out  1  channel 1 word accepted this cycle.
- s  out  1  combinational grant select: 0 = channel 0, 1 = channel 1. Feeds the 2:1 mux select.
- y_valid  out  1  output register holds a word.
- y_data  out  DATA_W  registered output word.
- y_src  out  1  source channel of y_data.
- y_ready  in  1  downstream accepts y_data this cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - y_valid=0, y_data=0, y_src=0, last-grant pointer=1, so channel 0 is favoured first.
  - Reset mid-transfer discards the held word, with no output glitch beyond y_valid dropping.
- Output register states:
  - EMPTY (y_valid=0) and FULL (y_valid=1).
  - can_load = !y_valid | y_ready.
- Grant (combinational, from i0_valid, i1_valid, pointer):
  - Neither valid: no grant; s holds the pointer's complement (the next-favoured channel).
  - One valid: grant that channel.
  - Both valid, PRIO_MODE=0: grant channel != last grant.
  - Both valid, PRIO_MODE=1: grant channel 0.
  - s = granted channel index.
- Ready signals:
  - iN_ready = can_load & grant==N.
  - The non-granted channel's ready is 0.
  - Ready never depends on the same channel's valid beyond grant logic. No combinational loop from y_ready to y_valid.
- Transfer on clk edge:
  - If granted channel valid & can_load: y_data <= granted data, y_src <= s, y_valid <= 1, pointer <= s.
  - Else if y_ready: y_valid <= 0, and y_data/y_src hold their last values.
  - Else all hold.
- Transitions:
  - EMPTY->FULL on accept.
  - FULL->FULL on simultaneous y_ready and accept (pass-through, latency 1 cycle, no bubble).
  - FULL->EMPTY on y_ready with no accept.
  - FULL stalls while y_ready=0: y_data/y_src/y_valid stable, both iN_ready=0.
- Pointer behaviour:
  - Updates only on an accepted transfer, never on idle cycles.
  - In PRIO_MODE=1 the pointer still updates but does not affect grant.
- Latency: input word appears on y_data the cycle after acceptance.
- Channel 0 and 1 words are never reordered within a channel.
- Fairness: under continuous both-valid with y_ready=1 in PRIO_MODE=0, grants strictly alternate 0,1,0,1.
- Source protocol: sources must hold valid and data until ready. The block does not check this.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, all inputs 0 -> y_valid=0, y_data=0, y_src=0, i0_ready=i1_ready=0, s=0.
- Single channel stream: i1_valid=1, data 0x11,0x22,0x33 on consecutive cycles, y_ready=1 -> y_data 0x11,0x22,0x33 one cycle later each, y_src=1, no bubbles.
- Round-robin contention: PRIO_MODE=0, both valid continuously, i0_data=0xA0.., i1_data=0xB0.., y_ready=1 -> y_src sequence 0,1,0,1 and y_data 0xA0,0xB0,0xA1,0xB1.
- Backpressure: FULL with y_data=0x5A, y_ready=0 for 4 cycles, both sources valid -> y_data stays 0x5A, i0_ready=i1_ready=0. On y_ready=1 the next granted word loads the same cycle.
- Fixed priority: PRIO_MODE=1, both valid 4 cycles, y_ready=1 -> four channel-0 words, i1_ready=0 throughout. Drop i0_valid -> channel 1 granted next cycle.
- Async reset mid-operation: assert rst_n low between clock edges while FULL with y_data=0x7E -> y_valid=0 and y_data=0 immediately. After release, first grant with both valid goes to channel 0.

Source files
------------

// File: rtl/rr_mux_2x1_ctrl.sv
// Two-channel arbiter with a single-entry output register; s drives the select of
// the downstream 2:1 data mux and y_src tags each word with its source channel.
module rr_mux_2x1_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i0_valid,
    input  logic [DATA_W-1:0] i0_data,
    output logic              i0_ready,
    input  logic              i1_valid,
    input  logic [DATA_W-1:0] i1_data,
    output logic              i1_ready,
    output logic              s,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    output logic              y_src,
    input  logic              y_ready
);

    localparam bit FIXED_PRIO = (PRIO_MODE != 32'd0);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    logic   ptr;        // last granted channel
    logic   any_valid;
    logic   can_load;
    logic   load;

    // Grant select and ready generation; with no requester, s points at the favoured channel
    always_comb begin
        s         = ~ptr;
        any_valid = 1'b0;
        can_load  = 1'b0;
        i0_ready  = 1'b0;
        i1_ready  = 1'b0;
        load      = 1'b0;

        any_valid = i0_valid | i1_valid;
        if (i0_valid && i1_valid) begin
            s = FIXED_PRIO ? 1'b0 : ~ptr;
        end else if (i0_valid) begin
            s = 1'b0;
        end else if (i1_valid) begin
            s = 1'b1;
        end

        can_load = (state == EMPTY) | y_ready;
        i0_ready = can_load & any_valid & ~s;
        i1_ready = can_load & any_valid & s;
        load     = i0_ready | i1_ready;
    end

    assign y_valid = (state == FULL);

    // Output register and pointer; pointer moves only on an accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            y_data <= '0;
            y_src  <= 1'b0;
            ptr    <= 1'b1;
        end else if (load) begin
            state  <= FULL;
            y_data <= s ? i1_data : i0_data;
            y_src  <= s;
            ptr    <= s;
        end else if (y_ready) begin
            state  <= EMPTY;
        end
    end

endmodule
